// File: rtl/mult_4bit_seq.sv
// mult_4bit_seq: sequential 4x4 unsigned shift-and-add multiplier.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-high reset
//   start    in   1  request, sampled only in IDLE
//   a        in   4  multiplicand, latched when start is accepted
//   b        in   4  multiplier, latched when start is accepted
//   busy     out  1  high while iterating (CALC)
//   done     out  1  one-cycle pulse, product valid
//   product  out  8  {A,Q} of the last completed operation
//
// Also contains adder_4bit, the 4-bit ripple adder the datapath is built on.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands latched on accept
// CALC  | one shift-and-add iteration per cycle, four cycles total
// DONE  | done pulse for one cycle; returns to IDLE, start ignored

module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] out,
  output logic       c_out
);
  assign {c_out, out} = a + b + {4'd0, c_in};
endmodule

module mult_4bit_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [3:0] a_q, a_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;

  logic [3:0] add_out;
  logic       add_cout;
  logic       carry;
  logic [3:0] a_src;
  logic [7:0] shifted;

  adder_4bit u_adder (
    .a     (a_q),
    .b     (m_q),
    .c_in  (1'b0),
    .out   (add_out),
    .c_out (add_cout)
  );

  // {C,A,Q} >> 1: the carry of this iteration lands directly in A[3].
  // After the shift the C bit is always zero, so it never needs its own
  // flop; it only exists for the duration of the combinational step.
  always_comb begin
    carry   = q_q[0] ? add_cout : 1'b0;
    a_src   = q_q[0] ? add_out  : a_q;
    shifted = {carry, a_src, q_q[3:1]};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          a_d     = 4'd0;
          cnt_d   = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d   = shifted[7:4];
        q_d   = shifted[3:0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d   = DONE;
          product_d = shifted;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= 4'd0;
      q_q       <= 4'd0;
      a_q       <= 4'd0;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult_4bit_seq.sv
module tb_mult_4bit_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int errors = 0;
  int checks = 0;
  logic [7:0] last_prod;

  mult_4bit_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation from an idle machine; expected product is plain x*y.
  task automatic do_op(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] exp_p;
    exp_p = 8'(x) * 8'(y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
      end
      chk("busy_calc", {7'd0, busy}, 8'd1);
      chk("done_calc", {7'd0, done}, 8'd0);
      chk("prod_hold", product, last_prod);
    end
    @(negedge clk);
    chk("busy_done", {7'd0, busy}, 8'd0);
    chk("done_pulse", {7'd0, done}, 8'd1);
    chk("product", product, exp_p);
    last_prod = exp_p;
    @(negedge clk);
    chk("busy_idle", {7'd0, busy}, 8'd0);
    chk("done_fall", {7'd0, done}, 8'd0);
    chk("prod_after", product, exp_p);
  endtask

  initial begin
    logic       exp_busy;
    logic       exp_done;
    logic [7:0] exp_prod;

    rst = 1'b1;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    last_prod = 8'h00;
    #1;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_prod", product, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op(4'd3, 4'd5);
    do_op(4'd15, 4'd15);
    do_op(4'd7, 4'd0);
    do_op(4'd0, 4'd9);

    // start held high; operands change mid-CALC and must not disturb the result
    @(negedge clk);
    a = 4'd2;
    b = 4'd6;
    start = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a = 4'd15;
        b = 4'd15;
      end
      exp_busy = (n <= 3) || (n >= 6 && n <= 9);
      exp_done = (n == 4) || (n == 10);
      exp_prod = (n < 4) ? last_prod : ((n < 10) ? 8'h0C : 8'hE1);
      chk("held_busy", {7'd0, busy}, {7'd0, exp_busy});
      chk("held_done", {7'd0, done}, {7'd0, exp_done});
      chk("held_prod", product, exp_prod);
    end
    start = 1'b0;
    last_prod = 8'hE1;

    // asynchronous reset in the second CALC cycle
    @(negedge clk);
    a = 4'd9;
    b = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_done", {7'd0, done}, 8'd0);
    chk("arst_prod", product, 8'h00);
    last_prod = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk("arst_no_done", {7'd0, done}, 8'd0);
      chk("arst_no_busy", {7'd0, busy}, 8'd0);
    end
    do_op(4'd9, 4'd9);

    for (int n = 0; n < 40; n++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_op(4'(x), 4'(y));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
